// File: rtl/addbit_pipe_if.sv
// Operand/result handshake bundle for addbit_pipe: valid/ready on both sides
// plus operands, mode and result flags.
interface addbit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/addbit_pipe.sv
// Pipelined add/subtract: each stage resolves one SEG-bit slice and passes its
// carry, operands and partial sum to the next stage under valid/ready flow control.
module addbit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  addbit_pipe_if.slave  bus
);
  localparam int SEG = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] v_r;
  logic              ovf_r;

  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  s_s [STAGES];
  logic [STAGES-1:0] c_s;
  logic [STAGES-1:0] ld_s;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] room_s;
  logic              ovf_s;

  // Flow control (room ripples back from the consumer) and per-stage slice adders
  always_comb begin
    logic             run;
    logic [SEG:0]     seg;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] ps;
    logic             pc;
    int               prv;
    int               nxt;
    room_s = {STAGES{1'b0}};
    ld_s   = {STAGES{1'b0}};
    adv_s  = {STAGES{1'b0}};
    c_s    = {STAGES{1'b0}};
    ovf_s  = 1'b0;
    run = !v_r[STAGES-1] || bus.out_ready;
    room_s[STAGES-1] = run;
    for (int k = STAGES - 2; k >= 0; k--) begin
      run = !v_r[k] || run;
      room_s[k] = run;
    end
    for (int k = 0; k < STAGES; k++) begin
      prv = (k > 0) ? k - 1 : 0;
      nxt = (k < STAGES - 1) ? k + 1 : k;
      // Stage 0 folds the subtract inversion into b so later stages only add
      if (k == 0) begin
        pa = bus.a;
        pb = bus.b ^ {WIDTH{bus.sub}};
        ps = {WIDTH{1'b0}};
        pc = bus.ci;
        ld_s[k] = bus.in_valid && room_s[0];
      end else begin
        pa = a_r[prv];
        pb = b_r[prv];
        ps = s_r[prv];
        pc = c_r[prv];
        ld_s[k] = v_r[prv] && room_s[k];
      end
      if (k < STAGES - 1) begin
        adv_s[k] = v_r[k] && room_s[nxt];
      end else begin
        adv_s[k] = v_r[k] && bus.out_ready;
      end
      seg = {1'b0, pa[k*SEG +: SEG]} + {1'b0, pb[k*SEG +: SEG]} + {{SEG{1'b0}}, pc};
      ps[k*SEG +: SEG] = seg[SEG-1:0];
      a_s[k] = pa;
      b_s[k] = pb;
      s_s[k] = ps;
      c_s[k] = seg[SEG];
    end
    // Carry into the MSB is recovered as a^b^sum at that bit
    ovf_s = a_s[STAGES-1][WIDTH-1] ^ b_s[STAGES-1][WIDTH-1]
          ^ s_s[STAGES-1][WIDTH-1] ^ c_s[STAGES-1];
  end

  // Stage registers: load on handshake, clear valid on advance, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r   <= {STAGES{1'b0}};
      c_r   <= {STAGES{1'b0}};
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        s_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld_s[k]) begin
          v_r[k] <= 1'b1;
          a_r[k] <= a_s[k];
          b_r[k] <= b_s[k];
          s_r[k] <= s_s[k];
          c_r[k] <= c_s[k];
        end else if (adv_s[k]) begin
          v_r[k] <= 1'b0;
        end else begin
          v_r[k] <= v_r[k];
        end
      end
      if (ld_s[STAGES-1]) begin
        ovf_r <= ovf_s;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign bus.in_ready  = room_s[0];
  assign bus.out_valid = v_r[STAGES-1];
  assign bus.sum       = s_r[STAGES-1];
  assign bus.co        = c_r[STAGES-1];
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_addbit_pipe.sv
// Directed bench for addbit_pipe at STAGES 1, 2 and 8 (WIDTH 8), plus a
// scoreboarded random stream with random backpressure on the 2-stage build.
module tb_addbit_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       ci;
  logic       sub;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] q[$];

  addbit_pipe_if #(.WIDTH(8)) i1 ();
  addbit_pipe_if #(.WIDTH(8)) i2 ();
  addbit_pipe_if #(.WIDTH(8)) i8 ();

  assign i1.in_valid = in_valid; assign i1.a = a; assign i1.b = b;
  assign i1.ci = ci; assign i1.sub = sub; assign i1.out_ready = out_ready;
  assign i2.in_valid = in_valid; assign i2.a = a; assign i2.b = b;
  assign i2.ci = ci; assign i2.sub = sub; assign i2.out_ready = out_ready;
  assign i8.in_valid = in_valid; assign i8.a = a; assign i8.b = b;
  assign i8.ci = ci; assign i8.sub = sub; assign i8.out_ready = out_ready;

  addbit_pipe #(.WIDTH(8), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  addbit_pipe #(.WIDTH(8), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  addbit_pipe #(.WIDTH(8), .STAGES(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, co, sum[7:0]} from plain arithmetic and sign rules
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    logic [7:0] yy;
    logic [8:0] r;
    logic       v;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {8'd0, c};
    v  = (x[7] == yy[7]) && (r[7] != x[7]);
    return {v, r};
  endfunction

  // One operand set into all three builds; each must show it after STAGES edges
  task automatic latency(input logic [7:0] xa, input logic [7:0] xb,
                         input logic xc, input logic xs, input logic [9:0] e);
    a = xa; b = xb; ci = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("s1_valid", i1.out_valid, 1);
    chk("s1_result", {i1.ovf, i1.co, i1.sum}, e);
    chk("s2_valid_early", i2.out_valid, 0);
    tick;
    chk("s1_popped", i1.out_valid, 0);
    chk("s2_valid", i2.out_valid, 1);
    chk("s2_result", {i2.ovf, i2.co, i2.sum}, e);
    for (int n = 3; n <= 8; n++) begin
      tick;
      chk("s8_valid", i8.out_valid, 32'(n == 8));
    end
    chk("s8_result", {i8.ovf, i8.co, i8.sum}, e);
  endtask

  initial begin
    logic [7:0] hs;
    logic       hc;
    logic       ho;
    logic       stall;
    logic [9:0] exp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; ci = 1'b0; sub = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", i2.out_valid, 0);
    chk("rst_in_ready", i2.in_ready, 1);
    chk("rst_result", {i2.ovf, i2.co, i2.sum}, 10'h000);
    chk("rst_s1_valid", i1.out_valid, 0);
    chk("rst_s8_valid", i8.out_valid, 0);

    latency(8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
    latency(8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
    latency(8'h05, 8'h07, 1'b1, 1'b1, 10'h0FE);
    tick; tick;

    // Backpressure: two sets fill the 2-stage pipe, the third waits at the input
    out_ready = 1'b0;
    a = 8'h01; b = 8'h02; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    #1; chk("bp_ready1", i2.in_ready, 1);
    tick;
    a = 8'h10; b = 8'h20;
    #1; chk("bp_ready2", i2.in_ready, 1);
    tick;
    a = 8'h30; b = 8'h40;
    #1; chk("bp_ready_full", i2.in_ready, 0);
    chk("bp_first", {i2.out_valid, i2.sum}, 9'h103);
    tick;
    chk("bp_ready_hold", i2.in_ready, 0);
    chk("bp_stable", {i2.out_valid, i2.ovf, i2.co, i2.sum}, 11'h403);
    out_ready = 1'b1;
    #1; chk("bp_ready_release", i2.in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_second", {i2.out_valid, i2.sum}, 9'h130);
    tick;
    chk("bp_third", {i2.out_valid, i2.sum}, 9'h170);
    tick;
    chk("bp_empty", i2.out_valid, 0);

    // Random stream with random backpressure against the reference queue
    stall = 1'b0; hs = 8'h00; hc = 1'b0; ho = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      a = 8'($urandom); b = 8'($urandom);
      ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      if (stall) begin
        chk("stall_valid", i2.out_valid, 1);
        chk("stall_result", {i2.ovf, i2.co, i2.sum}, {ho, hc, hs});
      end
      if (in_valid && i2.in_ready) q.push_back(model(a, b, ci, sub));
      if (i2.out_valid && out_ready) begin
        chk("rand_have_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          chk("rand_result", {i2.ovf, i2.co, i2.sum}, exp);
        end
      end
      stall = i2.out_valid && !out_ready;
      hs = i2.sum; hc = i2.co; ho = i2.ovf;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      #1;
      if (i2.out_valid) begin
        exp = q.pop_front();
        chk("drain_result", {i2.ovf, i2.co, i2.sum}, exp);
      end
      tick;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", i2.out_valid, 0);

    // Reset with two results in flight and an operand offered during reset
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick;
    a = 8'h33; b = 8'h44;
    tick;
    chk("pre_rst_full", {i2.out_valid, i2.in_ready}, 2'b10);
    a = 8'hAA; b = 8'h55; rst_n = 1'b0;
    tick;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", i2.out_valid, 0);
    chk("mid_rst_ready", i2.in_ready, 1);
    chk("mid_rst_result", {i2.ovf, i2.co, i2.sum}, 10'h000);
    for (int n = 0; n < 4; n++) begin
      tick;
      chk("no_stale", i2.out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
